// File: rtl/hazard_pkg.sv
// Shared types and encodings for the hazard/forwarding controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: result-source codes, forward-select codes, Tnew/Tuse constants,
//           the shadow-stage record stage_info_t and the Tnew-at-entry helper.
package hazard_pkg;

  localparam int RA_WIDTH = 5;
  localparam int T_WIDTH  = 2;

  // Result source of the instruction writing wa.
  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_DM  = 2'b01;
  localparam logic [1:0] SRC_PC8 = 2'b10;

  // Forward selects for the D and E operand muxes.
  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_ALUM = 2'b01;
  localparam logic [1:0] FWD_PC8M = 2'b10;
  localparam logic [1:0] FWD_WD   = 2'b11;

  // Forward selects for the M-stage store-data mux.
  localparam logic [1:0] FWD_M_RD2 = 2'b00;
  localparam logic [1:0] FWD_M_WD  = 2'b01;

  // Tnew on entry to E. PC+8 is only muxed out of M, so it behaves like ALU.
  localparam logic [T_WIDTH-1:0] TNEW_ALU = 2'd1;
  localparam logic [T_WIDTH-1:0] TNEW_DM  = 2'd2;
  localparam logic [T_WIDTH-1:0] TNEW_PC8 = 2'd1;

  // Tuse: how many cycles after D the operand is consumed.
  localparam logic [T_WIDTH-1:0] TUSE_D = 2'd0;
  localparam logic [T_WIDTH-1:0] TUSE_E = 2'd1;
  localparam logic [T_WIDTH-1:0] TUSE_M = 2'd2;

  typedef struct packed {
    logic [RA_WIDTH-1:0] rs;
    logic [RA_WIDTH-1:0] rt;
    logic [RA_WIDTH-1:0] wa;
    logic [T_WIDTH-1:0]  tnew;
    logic [1:0]          src;
  } stage_info_t;

  // Unused source code 2'b11 is treated like an ALU result.
  function automatic logic [T_WIDTH-1:0] tnew_of(input logic [1:0] src);
    case (src)
      SRC_DM:  return TNEW_DM;
      SRC_PC8: return TNEW_PC8;
      default: return TNEW_ALU;
    endcase
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// D-stage instruction info in, stall and forward selects out.
// Latency: outputs combinational from controller state plus D fields.
// Backpressure: none; stall is the only flow control (holds D).
// Ports: rs_D/rt_D/use_*/tuse_*/wa_D/src_D from decode; stall, fwd_* and
//        (with STALL_CNT_EN) stall_count back to the datapath.
interface hazard_fwd_ctrl_if #(
  parameter int RA_W  = 5,
  parameter int T_W   = 2,
  parameter int CNT_W = 32
);
  logic [RA_W-1:0] rs_D;
  logic [RA_W-1:0] rt_D;
  logic            use_rs_D;
  logic            use_rt_D;
  logic [T_W-1:0]  tuse_rs_D;
  logic [T_W-1:0]  tuse_rt_D;
  logic [RA_W-1:0] wa_D;
  logic [1:0]      src_D;

  logic            stall;
  logic [1:0]      fwd_rs_D;
  logic [1:0]      fwd_rt_D;
  logic [1:0]      fwd_rs_E;
  logic [1:0]      fwd_rt_E;
  logic [1:0]      fwd_rt_M;
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_count;
`else
  logic [CNT_W-1:0] stall_count_unused;
  assign stall_count_unused = '0;
`endif

  modport master (
    output rs_D, rt_D, use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D, wa_D, src_D,
    input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
`ifdef STALL_CNT_EN
    , input stall_count
`endif
  );

  modport slave (
    input  rs_D, rt_D, use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D, wa_D, src_D,
    output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
`ifdef STALL_CNT_EN
    , output stall_count
`endif
  );

endinterface

// File: rtl/hz_stage_reg.sv
// One shadow pipeline stage: loads the upstream record, or a bubble.
// Latency: 1 cycle (registered).
// Backpressure: none; always advances, bubble replaces the load.
// Ports: clk, reset (sync, active-high), bubble, d (upstream record), q.
// DEC=1 decrements tnew (saturating at 0) as the record moves in.
module hz_stage_reg
  import hazard_pkg::*;
#(
  parameter bit DEC = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  stage_info_t d,
  output stage_info_t q
);

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      q <= '0;
    end else begin
      q <= d;
      if (DEC && (d.tnew != '0)) begin
        q.tnew <= d.tnew - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline.
// Latency: stall/fwd combinational from registered shadow E/M/W plus D fields.
// Backpressure: stall holds PC and IF/ID and injects a bubble into E.
// Ports: clk, reset (sync, active-high), hz (hazard_fwd_ctrl_if.slave).
// Optional macro STALL_CNT_EN adds the saturating hz.stall_count counter.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W  = RA_WIDTH,
  parameter int T_W   = T_WIDTH,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  hazard_fwd_ctrl_if.slave  hz
);

  stage_info_t d_info;
  stage_info_t st_e;
  stage_info_t st_m;
  stage_info_t st_w;
  logic        stall_w;

  always_comb begin
    d_info      = '0;
    d_info.rs   = hz.rs_D;
    d_info.rt   = hz.rt_D;
    d_info.wa   = hz.wa_D;
    d_info.src  = hz.src_D;
    d_info.tnew = tnew_of(hz.src_D);
  end

  // E takes Tnew-at-entry straight from the source, so it does not decrement.
  hz_stage_reg #(.DEC(1'b0)) u_stage_e (
    .clk    (clk),
    .reset  (reset),
    .bubble (stall_w),
    .d      (d_info),
    .q      (st_e)
  );

  hz_stage_reg #(.DEC(1'b1)) u_stage_m (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .d      (st_e),
    .q      (st_m)
  );

  hz_stage_reg #(.DEC(1'b1)) u_stage_w (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .d      (st_m),
    .q      (st_w)
  );

  // A producer in E or M whose result is not ready by the time the operand
  // is consumed forces a stall. $0 never creates a dependency.
  function automatic logic op_stall(input logic            use_r,
                                    input logic [RA_W-1:0] r,
                                    input logic [T_W-1:0]  tuse,
                                    input stage_info_t     e,
                                    input stage_info_t     m);
    return use_r && (r != '0) &&
           (((e.wa == r) && (e.tnew > tuse)) ||
            ((m.wa == r) && (m.tnew > tuse)));
  endfunction

  // M beats W. A load sitting in M is never ready there, so an M hit only
  // counts for ALU/PC+8 results; otherwise fall through to W.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] r,
                                         input stage_info_t     m,
                                         input stage_info_t     w);
    if (r == '0)
      return FWD_REG;
    else if ((m.wa == r) && (m.tnew == '0) && (m.src == SRC_PC8))
      return FWD_PC8M;
    else if ((m.wa == r) && (m.tnew == '0) && (m.src != SRC_DM))
      return FWD_ALUM;
    else if ((w.wa == r) && (w.tnew == '0))
      return FWD_WD;
    else
      return FWD_REG;
  endfunction

  assign stall_w = op_stall(hz.use_rs_D, hz.rs_D, hz.tuse_rs_D, st_e, st_m) ||
                   op_stall(hz.use_rt_D, hz.rt_D, hz.tuse_rt_D, st_e, st_m);

  assign hz.stall    = stall_w;
  assign hz.fwd_rs_D = fwd_sel(hz.rs_D, st_m, st_w);
  assign hz.fwd_rt_D = fwd_sel(hz.rt_D, st_m, st_w);
  assign hz.fwd_rs_E = fwd_sel(st_e.rs, st_m, st_w);
  assign hz.fwd_rt_E = fwd_sel(st_e.rt, st_m, st_w);
  assign hz.fwd_rt_M = ((st_w.wa == st_m.rt) && (st_m.rt != '0)) ? FWD_M_WD
                                                                   : FWD_M_RD2;

  // Fields carried only to keep the stage record uniform.
  logic unused_bits;
  assign unused_bits = ^{st_w.rs, st_w.rt, st_w.src, st_m.rs};

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_w && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign hz.stall_count = stall_cnt;
`else
  logic [CNT_W-1:0] stall_cnt_unused;
  assign stall_cnt_unused = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: instruction pairs through D.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: bench holds D while stall is high, like IF/ID would.
module tb_hazard_fwd_ctrl;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  localparam logic [1:0] ALU = 2'b00;
  localparam logic [1:0] DM  = 2'b01;
  localparam logic [1:0] PC8 = 2'b10;

  hazard_fwd_ctrl_if #(.RA_W(5), .T_W(2), .CNT_W(32)) hz_if ();

  hazard_fwd_ctrl #(.RA_W(5), .T_W(2), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic ut,
                       input logic [1:0] tr, input logic [1:0] tt,
                       input logic [4:0] wa, input logic [1:0] src);
    hz_if.rs_D      = rs;
    hz_if.rt_D      = rt;
    hz_if.use_rs_D  = ur;
    hz_if.use_rt_D  = ut;
    hz_if.tuse_rs_D = tr;
    hz_if.tuse_rt_D = tt;
    hz_if.wa_D      = wa;
    hz_if.src_D     = src;
  endtask

  task automatic nop();
    set_d(5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, ALU);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic flush();
    repeat (3) begin
      nop();
      step();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    nop();
    step();
    step();
    reset = 1'b0;

    // Reset state: D reads $1 but no producer is tracked.
    set_d(5'd1, 5'd1, 1'b1, 1'b1, 2'd0, 2'd0, 5'd0, ALU);
    smp();
    chk("rst_stall",    hz_if.stall,    0);
    chk("rst_fwd_rs_D", hz_if.fwd_rs_D, 0);
    chk("rst_fwd_rt_D", hz_if.fwd_rt_D, 0);
    chk("rst_fwd_rs_E", hz_if.fwd_rs_E, 0);
    chk("rst_fwd_rt_E", hz_if.fwd_rt_E, 0);
    chk("rst_fwd_rt_M", hz_if.fwd_rt_M, 0);
`ifdef STALL_CNT_EN
    chk("rst_stall_count", hz_if.stall_count, 0);
`endif
    step();
    flush();

    // 1: addu $1 ; addu $2,$1,$1 -> no stall, E forwards from ALUC_M.
    set_d(5'd2, 5'd3, 1'b1, 1'b1, 2'd1, 2'd1, 5'd1, ALU);
    smp(); chk("t1_issue_stall", hz_if.stall, 0); step();
    set_d(5'd1, 5'd1, 1'b1, 1'b1, 2'd1, 2'd1, 5'd2, ALU);
    smp(); chk("t1_use_stall", hz_if.stall, 0); step();
    nop();
    smp();
    chk("t1_fwd_rs_E", hz_if.fwd_rs_E, 1);
    chk("t1_fwd_rt_E", hz_if.fwd_rt_E, 1);
    step(); flush();

    // 2: lw $1 ; addu $2,$1,$3 -> one stall, then rs forwarded from WData.
    set_d(5'd29, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd1, DM);
    smp(); chk("t2_issue_stall", hz_if.stall, 0); step();
    set_d(5'd1, 5'd3, 1'b1, 1'b1, 2'd1, 2'd1, 5'd2, ALU);
    smp(); chk("t2_stall_1", hz_if.stall, 1); step();
    smp(); chk("t2_stall_released", hz_if.stall, 0); step();
    nop();
    smp();
    chk("t2_fwd_rs_E", hz_if.fwd_rs_E, 3);
    chk("t2_fwd_rt_E", hz_if.fwd_rt_E, 0);
    step(); flush();

    // 3a: addu $1 ; beq $1,$0 -> one stall, then ALUC_M at D.
    set_d(5'd2, 5'd3, 1'b1, 1'b1, 2'd1, 2'd1, 5'd1, ALU);
    smp(); step();
    set_d(5'd1, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 5'd0, ALU);
    smp(); chk("t3a_stall_1", hz_if.stall, 1); step();
    smp();
    chk("t3a_stall_released", hz_if.stall, 0);
    chk("t3a_fwd_rs_D", hz_if.fwd_rs_D, 1);
    chk("t3a_fwd_rt_D", hz_if.fwd_rt_D, 0);
    step(); flush();

    // 3b: lw $1 ; beq $1,$0 -> two stalls, then WData at D.
    set_d(5'd29, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd1, DM);
    smp();
`ifdef STALL_CNT_EN
    chk("t3b_count_before", hz_if.stall_count, 2);
`endif
    step();
    set_d(5'd1, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 5'd0, ALU);
    smp(); chk("t3b_stall_1", hz_if.stall, 1); step();
    smp(); chk("t3b_stall_2", hz_if.stall, 1); step();
    smp();
    chk("t3b_stall_released", hz_if.stall, 0);
    chk("t3b_fwd_rs_D", hz_if.fwd_rs_D, 3);
`ifdef STALL_CNT_EN
    chk("t3b_count_after", hz_if.stall_count, 4);
`endif
    step(); flush();

    // 4: jal ; jr $31 -> one stall, then PC4_M+4 at D.
    set_d(5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd31, PC8);
    smp(); step();
    set_d(5'd31, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd0, ALU);
    smp(); chk("t4_stall_1", hz_if.stall, 1); step();
    smp();
    chk("t4_stall_released", hz_if.stall, 0);
    chk("t4_fwd_rs_D", hz_if.fwd_rs_D, 2);
    step(); flush();

    // 5: lw $5 ; sw $5 -> no stall; store data forwarded in M.
    set_d(5'd29, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd5, DM);
    smp(); step();
    set_d(5'd29, 5'd5, 1'b1, 1'b1, 2'd1, 2'd2, 5'd0, ALU);
    smp(); chk("t5_stall", hz_if.stall, 0); step();
    nop();
    smp(); chk("t5_fwd_rt_E", hz_if.fwd_rt_E, 0); step();
    smp(); chk("t5_fwd_rt_M", hz_if.fwd_rt_M, 1); step();
    flush();

    // 5b: lw $0 ; beq $0,$0 -> never stalls, nothing forwarded.
    set_d(5'd29, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd0, DM);
    smp(); step();
    set_d(5'd0, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 5'd0, ALU);
    smp();
    chk("t5b_stall",    hz_if.stall,    0);
    chk("t5b_fwd_rs_D", hz_if.fwd_rs_D, 0);
    chk("t5b_fwd_rt_D", hz_if.fwd_rt_D, 0);
    step();
    nop();
    smp(); chk("t5b_fwd_rs_E", hz_if.fwd_rs_E, 0); step();
    flush();

    // M beats W: addu $1 ; addu $1 ; beq $1 -> after stall, ALUC_M.
    set_d(5'd2, 5'd3, 1'b1, 1'b1, 2'd1, 2'd1, 5'd1, ALU);
    smp(); step();
    set_d(5'd2, 5'd3, 1'b1, 1'b1, 2'd1, 2'd1, 5'd1, ALU);
    smp(); step();
    set_d(5'd1, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 5'd0, ALU);
    smp(); chk("mw_stall_1", hz_if.stall, 1); step();
    smp(); chk("mw_fwd_rs_D", hz_if.fwd_rs_D, 1); step();
    flush();

    // 6: reset during a lw-use stall -> clean state on the next cycle.
    set_d(5'd29, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd1, DM);
    smp(); step();
    set_d(5'd1, 5'd3, 1'b1, 1'b1, 2'd1, 2'd1, 5'd2, ALU);
    smp(); chk("t6_stall_before_rst", hz_if.stall, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    smp();
    chk("t6_stall",    hz_if.stall,    0);
    chk("t6_fwd_rs_D", hz_if.fwd_rs_D, 0);
    chk("t6_fwd_rt_D", hz_if.fwd_rt_D, 0);
    chk("t6_fwd_rs_E", hz_if.fwd_rs_E, 0);
    chk("t6_fwd_rt_E", hz_if.fwd_rt_E, 0);
    chk("t6_fwd_rt_M", hz_if.fwd_rt_M, 0);
`ifdef STALL_CNT_EN
    chk("t6_stall_count", hz_if.stall_count, 0);
`endif
    step();
    smp(); chk("t6_stall_next", hz_if.stall, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
